// File: rtl/pattern_det_ctrl_if.sv
// Host/bit-source bundle for pattern_det_ctrl: run control, configuration, serial input and status.
interface pattern_det_ctrl_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] cfg_pat;
    logic [3:0]       cfg_len;
    logic [WIN_W-1:0] cfg_win;
    logic             din;
    logic             din_vld;
    logic             busy;
    logic             hit;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output start, abort, cfg_pat, cfg_len, cfg_win, din, din_vld,
        input  busy, hit, done, err, match_cnt
    );

    modport slave (
        input  start, abort, cfg_pat, cfg_len, cfg_win, din, din_vld,
        output busy, hit, done, err, match_cnt
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Run-controlled programmable serial pattern detector with saturating match count.
// Define OVERLAP_EN for overlapping detection; otherwise each match needs len fresh bits.
module pattern_det_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input logic              clk,
    input logic              rst,
    pattern_det_ctrl_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [3:0]        len_q, len_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIN_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              hit_q, hit_d;

    logic [PAT_W-1:0]  pat_mask;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic [WIN_W-1:0]  bitcnt_inc;
    logic              is_match;
    logic              cfg_bad;

    always_comb begin
        pat_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            pat_mask[i] = (i < 32'(len_q));
        end
    end

    // Match is judged on the post-shift history and post-increment fill.
    assign hist_shift = {hist_q[PAT_W-2:0], bus.din};
    assign fill_inc   = (32'(fill_q) >= PAT_W) ? fill_q : fill_q + FILL_W'(1);
    assign bitcnt_inc = bitcnt_q + WIN_W'(1);
    assign is_match   = (32'(fill_inc) >= 32'(len_q)) &&
                        ((hist_shift & pat_mask) == (pat_q & pat_mask));
    assign cfg_bad    = (bus.cfg_len == 4'd0) || (32'(bus.cfg_len) > PAT_W) ||
                        (bus.cfg_win == '0);

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        win_d    = win_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        hit_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    pat_d    = bus.cfg_pat;
                    len_d    = bus.cfg_len;
                    win_d    = bus.cfg_win;
                    hist_d   = '0;
                    fill_d   = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    err_d    = cfg_bad;
                    state_d  = cfg_bad ? StDone : StRun;
                end
            end
            StRun: begin
                // Abort discards any bit presented in the same cycle.
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.din_vld) begin
                    hist_d   = hist_shift;
                    fill_d   = fill_inc;
                    bitcnt_d = bitcnt_inc;
                    if (is_match) begin
                        hit_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`ifdef OVERLAP_EN
                        fill_d = fill_inc;
`else
                        fill_d = '0;
`endif
                    end
                    if (bitcnt_inc == win_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            len_q    <= '0;
            win_q    <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            win_q    <= win_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.hit       = hit_q;
    assign bus.err       = err_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Scoreboard bench for pattern_det_ctrl: stimulus queues expected hit/done events, a monitor checks them.
module tb_pattern_det_ctrl;
    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    pattern_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             hit;
        logic             done;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void expect_ev(input logic h, input logic d, input logic e, input int c);
        exp_t x;
        x.hit  = h;
        x.done = d;
        x.err  = e;
        x.cnt  = CNT_W'(c);
        exp_q.push_back(x);
    endfunction

    // Monitor: every hit/done the DUT presents must match the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (bus.hit === 1'b1 || bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got hit=%0b done=%0b cnt=%0d, expected none",
                             bus.hit, bus.done, bus.match_cnt);
                end else begin
                    x = exp_q.pop_front();
                    chk("ev_hit", int'(bus.hit), int'(x.hit));
                    chk("ev_done", int'(bus.done), int'(x.done));
                    chk("ev_err", int'(bus.err), int'(x.err));
                    chk("ev_cnt", int'(bus.match_cnt), int'(x.cnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    // Inputs are applied at a negedge and consumed by the following posedge.
    task automatic drive(input logic s, input logic a, input logic d, input logic v);
        bus.start   = s;
        bus.abort   = a;
        bus.din     = d;
        bus.din_vld = v;
        @(negedge clk);
    endtask

    task automatic start_run(input logic [7:0] pat, input logic [3:0] len, input logic [15:0] win);
        bus.cfg_pat = pat;
        bus.cfg_len = len;
        bus.cfg_win = win;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends n bits MSB-first; hitmask marks the bits that should produce a hit.
    task automatic send_stream(input logic [15:0] bits, input logic [15:0] hitmask,
                               input int n, input bit ends_run);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if (hitmask[n-1-i]) c++;
            if (ends_run && i == n - 1) expect_ev(hitmask[n-1-i], 1'b1, 1'b0, c);
            else if (hitmask[n-1-i]) expect_ev(1'b1, 1'b0, 1'b0, c);
            drive(1'b0, 1'b0, bits[n-1-i], 1'b1);
        end
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_vld = 0;
        bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_win = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_cnt", int'(bus.match_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Nominal: 0111 x3, hits after bits 4, 8, 12; done with the last.
        start_run(8'h07, 4'd4, 16'd12);
        chk("nom_busy", int'(bus.busy), 1);
        chk("nom_cnt0", int'(bus.match_cnt), 0);
        send_stream(16'b0111_0111_0111, 16'b0001_0001_0001, 12, 1'b1);
        chk("nom_busy_end", int'(bus.busy), 0);
        chk("nom_cnt", int'(bus.match_cnt), 3);
        chk("nom_err", int'(bus.err), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back start in first IDLE cycle; overlap behaviour on 1111.
        start_run(8'h03, 4'd2, 16'd4);
        chk("b2b_busy", int'(bus.busy), 1);
`ifdef OVERLAP_EN
        send_stream(16'b1111, 16'b0111, 4, 1'b1);
        chk("ovl_cnt", int'(bus.match_cnt), 3);
`else
        send_stream(16'b1111, 16'b0101, 4, 1'b1);
        chk("ovl_cnt", int'(bus.match_cnt), 2);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Configuration errors.
        expect_ev(1'b0, 1'b1, 1'b1, 0);
        start_run(8'h01, 4'd0, 16'd4);
        chk("cerr0_busy", int'(bus.busy), 0);
        chk("cerr0_err", int'(bus.err), 1);
        chk("cerr0_cnt", int'(bus.match_cnt), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_ev(1'b0, 1'b1, 1'b1, 0);
        start_run(8'h01, 4'd9, 16'd4);
        chk("cerr9_busy", int'(bus.busy), 0);
        chk("cerr9_err", int'(bus.err), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_ev(1'b0, 1'b1, 1'b1, 0);
        start_run(8'h01, 4'd1, 16'd0);
        chk("cerrw_busy", int'(bus.busy), 0);
        chk("cerrw_err", int'(bus.err), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // start with abort in IDLE is ignored.
        bus.cfg_pat = 8'h01; bus.cfg_len = 4'd1; bus.cfg_win = 16'd2;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sa_busy", int'(bus.busy), 0);
        chk("sa_err", int'(bus.err), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // start during RUN (with a bad config) must not restart the run.
        start_run(8'h07, 4'd4, 16'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        bus.cfg_len = 4'd0; bus.cfg_win = 16'd0;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("sr_busy", int'(bus.busy), 1);
        chk("sr_err", int'(bus.err), 0);
        send_stream(16'b11, 16'b01, 2, 1'b1);
        chk("sr_cnt", int'(bus.match_cnt), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation with stalls: 300 ones, din_vld alternating.
        start_run(8'h01, 4'd1, 16'd300);
        for (int i = 1; i <= 300; i++) begin
            expect_ev(1'b1, i == 300, 1'b0, (i > 255) ? 255 : i);
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            if (i < 300) drive(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 150) begin
                chk("sat_stall_cnt", int'(bus.match_cnt), 150);
                chk("sat_stall_busy", int'(bus.busy), 1);
            end
        end
        chk("sat_busy", int'(bus.busy), 0);
        chk("sat_cnt", int'(bus.match_cnt), 255);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort after 5 bits; the bit in the abort cycle is discarded.
        start_run(8'h07, 4'd4, 16'd12);
        send_stream(16'b01110, 16'b00010, 5, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("ab_busy", int'(bus.busy), 0);
        chk("ab_cnt", int'(bus.match_cnt), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        start_run(8'h07, 4'd4, 16'd12);
        chk("ab_restart_cnt", int'(bus.match_cnt), 0);
        chk("ab_restart_busy", int'(bus.busy), 1);

        // Reset mid-run, just after a hit.
        send_stream(16'b011, 16'b000, 3, 1'b0);
        expect_ev(1'b1, 1'b0, 1'b0, 1);
        bus.din = 1'b1;
        bus.din_vld = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_hit", int'(bus.hit), 0);
        chk("mrst_done", int'(bus.done), 0);
        chk("mrst_err", int'(bus.err), 0);
        chk("mrst_cnt", int'(bus.match_cnt), 0);
        @(negedge clk);
        bus.din_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
